// File: rtl/pc_unit_if.sv
// Purpose: bus bundle between the multicycle control unit and pc_unit.
// Ports (signals):
//   estado       control-FSM state (STATE_W bits)
//   pcsrc        next-PC source: 00 seq, 01 branch, 10 JAL, 11 JALR
//   branch_taken ALU branch condition, used only for pcsrc=01
//   immediate    signed byte offset (branch/JAL) or JALR addend
//   rs1_val      JALR base register value (byte address)
//   trap_ack     control unit accepts the pending trap
//   PC           current PC (registered, PC units)
//   pc_link      byte address of PC + 4 (rd value for JAL/JALR)
//   trap_req     misaligned-target trap pending
//   bad_target   byte address of the faulting target
// Modports: master = control unit side, slave = pc_unit side.
interface pc_unit_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned STATE_W = 4
);
    logic [STATE_W-1:0] estado;
    logic [1:0]         pcsrc;
    logic               branch_taken;
    logic [XLEN-1:0]    immediate;
    logic [XLEN-1:0]    rs1_val;
    logic               trap_ack;
    logic [XLEN-1:0]    PC;
    logic [XLEN-1:0]    pc_link;
    logic               trap_req;
    logic [XLEN-1:0]    bad_target;

    modport master (
        output estado, pcsrc, branch_taken, immediate, rs1_val, trap_ack,
        input  PC, pc_link, trap_req, bad_target
    );

    modport slave (
        input  estado, pcsrc, branch_taken, immediate, rs1_val, trap_ack,
        output PC, pc_link, trap_req, bad_target
    );
endinterface

// File: rtl/pc_unit.sv
// Purpose: program-counter unit for the multicycle RISC-V datapath. Holds PC,
//   computes the next PC for sequential, branch, JAL and JALR flow, supports
//   word- or byte-granular PC, and raises a misaligned-target trap that is held
//   until the control unit acknowledges it.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset (priority over all inputs)
//   bus    pc_unit_if.slave: estado, pcsrc, branch_taken, immediate, rs1_val,
//          trap_ack in; PC, pc_link, trap_req, bad_target out
module pc_unit #(
    parameter int unsigned              XLEN         = 32,
    parameter int unsigned              STATE_W      = 4,
    parameter logic [STATE_W-1:0]       UPDATE_STATE = 4'b1000,
    parameter bit                       WORD_ADDR    = 1'b1,
    parameter logic [XLEN-1:0]          RESET_PC     = '0,
    parameter logic [XLEN-1:0]          TRAP_VEC     = 32'h40
) (
    input  logic        clk,
    input  logic        reset,
    pc_unit_if.slave    bus
);

    typedef enum logic {RUN, TRAP} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   bad_q, bad_d;
    logic              trap_q, trap_d;

    logic [XLEN-1:0]   pcb;
    logic [XLEN-1:0]   seq_t;
    logic [XLEN-1:0]   jalr_sum;
    logic [XLEN-1:0]   target;
    logic              check_align;
    logic              misaligned;

    // Byte address of the current PC and the fall-through target.
    always_comb begin
        pcb   = WORD_ADDR ? {pc_q[XLEN-3:0], 2'b00} : pc_q;
        seq_t = pcb + XLEN'(4);
    end

    // Byte target; only computed (non-sequential) targets can be misaligned.
    always_comb begin
        jalr_sum    = bus.rs1_val + bus.immediate;
        target      = seq_t;
        check_align = 1'b0;
        unique case (bus.pcsrc)
            2'b00: begin
                target      = seq_t;
                check_align = 1'b0;
            end
            2'b01: begin
                target      = bus.branch_taken ? (pcb + bus.immediate) : seq_t;
                check_align = bus.branch_taken;
            end
            2'b10: begin
                target      = pcb + bus.immediate;
                check_align = 1'b1;
            end
            default: begin
                target      = {jalr_sum[XLEN-1:1], 1'b0};
                check_align = 1'b1;
            end
        endcase
        misaligned = check_align && (target[1:0] != 2'b00);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            trap_q  <= 1'b0;
            bad_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            trap_q  <= trap_d;
            bad_q   <= bad_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        trap_d  = trap_q;
        bad_d   = bad_q;
        unique case (state_q)
            RUN: begin
                if (bus.estado == UPDATE_STATE) begin
                    if (misaligned) begin
                        bad_d   = target;
                        trap_d  = 1'b1;
                        state_d = TRAP;
                    end else begin
                        pc_d = WORD_ADDR ? {2'b00, target[XLEN-1:2]} : target;
                    end
                end
            end
            default: begin
                // Acknowledge wins over any PC step requested on the same edge.
                if (bus.trap_ack) begin
                    pc_d    = TRAP_VEC;
                    trap_d  = 1'b0;
                    state_d = RUN;
                end
            end
        endcase
    end

    // Outputs
    always_comb begin
        bus.PC         = pc_q;
        bus.pc_link    = seq_t;
        bus.trap_req   = trap_q;
        bus.bad_target = bad_q;
    end

endmodule

// File: tb/tb_pc_unit.sv
// Purpose: directed, table-driven check of pc_unit in word mode and byte mode.
module tb_pc_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pc_unit_if #(.XLEN(32), .STATE_W(4)) bw ();
    pc_unit_if #(.XLEN(32), .STATE_W(4)) bb ();

    pc_unit #(.XLEN(32), .STATE_W(4), .UPDATE_STATE(4'b1000), .WORD_ADDR(1'b1),
              .RESET_PC(32'h0), .TRAP_VEC(32'h40))
        dut_w (.clk(clk), .reset(reset), .bus(bw));

    pc_unit #(.XLEN(32), .STATE_W(4), .UPDATE_STATE(4'b1000), .WORD_ADDR(1'b0),
              .RESET_PC(32'h0), .TRAP_VEC(32'h40))
        dut_b (.clk(clk), .reset(reset), .bus(bb));

    typedef struct {
        bit          b;        // 1: byte-mode DUT, 0: word-mode DUT
        logic [3:0]  estado;
        logic [1:0]  pcsrc;
        logic        taken;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic        ack;
        logic [31:0] exp_pc;
        logic        exp_trap;
        logic [31:0] exp_bad;
    } vec_t;

    vec_t vecs[$];
    int unsigned tests = 0;
    int unsigned fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit b, input logic [3:0] e, input logic [1:0] s,
                                input logic t, input logic [31:0] imm, input logic [31:0] rs1,
                                input logic ack, input logic [31:0] pc, input logic tr,
                                input logic [31:0] bad);
        vec_t v;
        v.b = b; v.estado = e; v.pcsrc = s; v.taken = t; v.imm = imm; v.rs1 = rs1;
        v.ack = ack; v.exp_pc = pc; v.exp_trap = tr; v.exp_bad = bad;
        return v;
    endfunction

    task automatic idle_all();
        bw.estado = 4'd0; bw.pcsrc = 2'b00; bw.branch_taken = 1'b0;
        bw.immediate = '0; bw.rs1_val = '0; bw.trap_ack = 1'b0;
        bb.estado = 4'd0; bb.pcsrc = 2'b00; bb.branch_taken = 1'b0;
        bb.immediate = '0; bb.rs1_val = '0; bb.trap_ack = 1'b0;
    endtask

    task automatic check_w(input string tag, input logic [31:0] pc, input logic tr,
                           input logic [31:0] bad);
        chk({tag, " w.PC"}, bw.PC, pc);
        chk({tag, " w.trap_req"}, {31'd0, bw.trap_req}, {31'd0, tr});
        chk({tag, " w.bad_target"}, bw.bad_target, bad);
        chk({tag, " w.pc_link"}, bw.pc_link, (pc << 2) + 32'd4);
    endtask

    task automatic check_b(input string tag, input logic [31:0] pc, input logic tr,
                           input logic [31:0] bad);
        chk({tag, " b.PC"}, bb.PC, pc);
        chk({tag, " b.trap_req"}, {31'd0, bb.trap_req}, {31'd0, tr});
        chk({tag, " b.bad_target"}, bb.bad_target, bad);
        chk({tag, " b.pc_link"}, bb.pc_link, pc + 32'd4);
    endtask

    task automatic apply(input vec_t v);
        idle_all();
        if (v.b) begin
            bb.estado = v.estado; bb.pcsrc = v.pcsrc; bb.branch_taken = v.taken;
            bb.immediate = v.imm; bb.rs1_val = v.rs1; bb.trap_ack = v.ack;
        end else begin
            bw.estado = v.estado; bw.pcsrc = v.pcsrc; bw.branch_taken = v.taken;
            bw.immediate = v.imm; bw.rs1_val = v.rs1; bw.trap_ack = v.ack;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Word mode (PC in words)
        vecs.push_back(mk(0, 4'd8, 2'b00, 0, 32'd0,        32'd0,     0, 32'd1,    0, 32'd0));   // seq
        vecs.push_back(mk(0, 4'd3, 2'b00, 0, 32'd0,        32'd0,     0, 32'd1,    0, 32'd0));   // hold
        vecs.push_back(mk(0, 4'd8, 2'b11, 0, 32'd0,        32'd40,    0, 32'd10,   0, 32'd0));   // JALR -> 10
        vecs.push_back(mk(0, 4'd8, 2'b01, 1, 32'hFFFFFFF8, 32'd0,     0, 32'd8,    0, 32'd0));   // taken -8
        vecs.push_back(mk(0, 4'd8, 2'b01, 0, 32'hFFFFFFF8, 32'd0,     0, 32'd9,    0, 32'd0));   // not taken
        vecs.push_back(mk(0, 4'd8, 2'b11, 0, 32'd3,        32'h41,    0, 32'h11,   0, 32'd0));   // JALR 0x44
        vecs.push_back(mk(0, 4'd3, 2'b10, 0, 32'd6,        32'd0,     1, 32'h11,   0, 32'd0));   // ack ignored in RUN
        vecs.push_back(mk(0, 4'd8, 2'b11, 0, 32'd0,        32'h43,    0, 32'h11,   1, 32'h42));  // misaligned JALR
        vecs.push_back(mk(0, 4'd8, 2'b00, 0, 32'd0,        32'd0,     0, 32'h11,   1, 32'h42));  // TRAP hold
        vecs.push_back(mk(0, 4'd8, 2'b00, 0, 32'd0,        32'd0,     1, 32'h40,   0, 32'h42));  // ack beats update
        vecs.push_back(mk(0, 4'd8, 2'b11, 0, 32'd0,        32'd20,    0, 32'd5,    0, 32'h42));  // PC=5
        vecs.push_back(mk(0, 4'd8, 2'b10, 0, 32'd6,        32'd0,     0, 32'd5,    1, 32'h1A));  // JAL 0x1A
        vecs.push_back(mk(0, 4'd8, 2'b10, 0, 32'd6,        32'd0,     0, 32'd5,    1, 32'h1A));  // no change
        vecs.push_back(mk(0, 4'd3, 2'b00, 0, 32'd0,        32'd0,     1, 32'h40,   0, 32'h1A));  // ack
        vecs.push_back(mk(0, 4'd8, 2'b11, 0, 32'd1,        32'h100,   0, 32'h40,   0, 32'h1A));  // JALR bit0 cleared
        vecs.push_back(mk(0, 4'd8, 2'b11, 0, 32'd0,        32'h103,   0, 32'h40,   1, 32'h102)); // JALR 0x102
        vecs.push_back(mk(0, 4'd0, 2'b00, 0, 32'd0,        32'd0,     1, 32'h40,   0, 32'h102)); // ack
        vecs.push_back(mk(0, 4'd8, 2'b01, 1, 32'd6,        32'd0,     0, 32'h40,   1, 32'h106)); // taken misaligned
        // Byte mode (PC in bytes), wrap-around
        vecs.push_back(mk(1, 4'd8, 2'b11, 0, 32'd0,        32'hFFFFFFFC, 0, 32'hFFFFFFFC, 0, 32'd0));
        vecs.push_back(mk(1, 4'd8, 2'b00, 0, 32'd0,        32'd0,     0, 32'd0,    0, 32'd0));   // wrap to 0
        vecs.push_back(mk(1, 4'd8, 2'b10, 0, 32'hFFFFFFFC, 32'd0,     0, 32'hFFFFFFFC, 0, 32'd0)); // wrap back
        vecs.push_back(mk(1, 4'd8, 2'b10, 0, 32'd2,        32'd0,     0, 32'hFFFFFFFC, 1, 32'hFFFFFFFE));
        vecs.push_back(mk(1, 4'd0, 2'b00, 0, 32'd0,        32'd0,     1, 32'h40,   0, 32'hFFFFFFFE));
        vecs.push_back(mk(1, 4'd8, 2'b01, 1, 32'h10,       32'd0,     0, 32'h50,   0, 32'hFFFFFFFE));

        idle_all();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_w("reset", 32'd0, 1'b0, 32'd0);
        check_b("reset", 32'd0, 1'b0, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            apply(vecs[i]);
            if (vecs[i].b)
                check_b($sformatf("v%0d", i), vecs[i].exp_pc, vecs[i].exp_trap, vecs[i].exp_bad);
            else
                check_w($sformatf("v%0d", i), vecs[i].exp_pc, vecs[i].exp_trap, vecs[i].exp_bad);
        end

        // Reset while both DUTs sit in TRAP, with ack and update also asserted.
        idle_all();
        check_w("pre_rst", 32'h40, 1'b1, 32'h106);
        bw.estado = 4'd8; bw.trap_ack = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_w("rst_trap", 32'd0, 1'b0, 32'd0);
        check_b("rst_trap", 32'd0, 1'b0, 32'd0);

        // Normal advance after reset, then not-taken branch with odd offset.
        idle_all();
        bw.estado = 4'd8; bw.pcsrc = 2'b00;
        @(posedge clk);
        #1;
        check_w("post_rst_seq", 32'd1, 1'b0, 32'd0);
        bw.pcsrc = 2'b01; bw.branch_taken = 1'b0; bw.immediate = 32'd3;
        @(posedge clk);
        #1;
        check_w("nt_odd_imm", 32'd2, 1'b0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
